// File: rtl/crash_sequencer_if.sv
// Control/level bundle between the CPU-side driver and the crash envelope sequencer.
interface crash_sequencer_if;
    logic       clk_48KHz_en;
    logic       wr_en;
    logic [3:0] wr_data;
    logic       trig_big;
    logic       trig_small;
    logic [3:0] crsh;
    logic       busy;
    logic       done;

    modport master (
        output clk_48KHz_en, wr_en, wr_data, trig_big, trig_small,
        input  crsh, busy, done
    );

    modport slave (
        input  clk_48KHz_en, wr_en, wr_data, trig_big, trig_small,
        output crsh, busy, done
    );
endinterface

// File: rtl/crash_sequencer.sv
// Crash-noise envelope: holds a start level, then steps it down to zero on 48 kHz ticks.
// A CPU write overrides everything and parks the level until the next trigger.
module crash_sequencer #(
    parameter int HOLD_TICKS  = 2400,
    parameter int DECAY_TICKS = 1200,
    parameter int BIG_LEVEL   = 15,
    parameter int SMALL_LEVEL = 8
) (
    input  logic              clk,
    input  logic              rst,
    crash_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HOLD   = 2'd1,
        DECAY  = 2'd2,
        MANUAL = 2'd3
    } state_t;

    localparam int CNT_MAX = ((HOLD_TICKS > DECAY_TICKS) ? HOLD_TICKS : DECAY_TICKS) - 1;
    localparam int CNT_W   = (CNT_MAX > 0) ? $clog2(CNT_MAX + 1) : 1;

    localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_TICKS - 1);
    localparam logic [CNT_W-1:0] DECAY_LOAD = CNT_W'(DECAY_TICKS - 1);
    // Start levels are clamped so the 4-bit level can never be loaded out of range.
    localparam logic [3:0]       BIG_L      = 4'((BIG_LEVEL > 15) ? 15 : BIG_LEVEL);
    localparam logic [3:0]       SMALL_L    = 4'((SMALL_LEVEL > 15) ? 15 : SMALL_LEVEL);

    state_t           state_r, state_s;
    logic [3:0]       crsh_r, crsh_s;
    logic [CNT_W-1:0] cnt_r, cnt_s;
    logic             busy_r;
    logic             done_r, done_s;
    logic             small_ok_s;

    // Next-state logic: write beats big trigger beats small trigger beats tick processing.
    always_comb begin
        state_s    = state_r;
        crsh_s     = crsh_r;
        cnt_s      = cnt_r;
        done_s     = 1'b0;
        small_ok_s = (crsh_r <= SMALL_L) || (state_r == IDLE);

        if (bus.wr_en) begin
            crsh_s  = bus.wr_data;
            cnt_s   = CNT_ZERO;
            state_s = (bus.wr_data != 4'd0) ? MANUAL : IDLE;
        end else if (bus.trig_big) begin
            crsh_s  = BIG_L;
            cnt_s   = HOLD_LOAD;
            state_s = HOLD;
        end else if (bus.trig_small && small_ok_s) begin
            crsh_s  = SMALL_L;
            cnt_s   = HOLD_LOAD;
            state_s = HOLD;
        end else if (bus.clk_48KHz_en) begin
            case (state_r)
                HOLD: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_s = cnt_r - CNT_ONE;
                    end else begin
                        cnt_s   = DECAY_LOAD;
                        state_s = DECAY;
                    end
                end
                DECAY: begin
                    if (cnt_r != CNT_ZERO) begin
                        cnt_s = cnt_r - CNT_ONE;
                    end else if (crsh_r <= 4'd1) begin
                        // Last step (the <= also guards a zero start level against wrapping).
                        crsh_s  = 4'd0;
                        cnt_s   = CNT_ZERO;
                        state_s = IDLE;
                        done_s  = 1'b1;
                    end else begin
                        crsh_s = crsh_r - 4'd1;
                        cnt_s  = DECAY_LOAD;
                    end
                end
                IDLE: begin
                    state_s = IDLE;
                end
                MANUAL: begin
                    state_s = MANUAL;
                end
                default: begin
                    state_s = IDLE;
                    crsh_s  = 4'd0;
                    cnt_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State, level, counter and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            crsh_r  <= 4'd0;
            cnt_r   <= CNT_ZERO;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            crsh_r  <= crsh_s;
            cnt_r   <= cnt_s;
            busy_r  <= (state_s != IDLE);
            done_r  <= done_s;
        end
    end

    assign bus.crsh = crsh_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;

endmodule

// File: tb/tb_crash_sequencer.sv
// Directed bench for crash_sequencer: HOLD=4/DECAY=2 main instance plus a HOLD=1/DECAY=1 instance.
module tb_crash_sequencer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    crash_sequencer_if bus ();
    crash_sequencer_if bus1 ();

    crash_sequencer #(.HOLD_TICKS(4), .DECAY_TICKS(2), .BIG_LEVEL(15), .SMALL_LEVEL(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    crash_sequencer #(.HOLD_TICKS(1), .DECAY_TICKS(1), .BIG_LEVEL(15), .SMALL_LEVEL(8)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int errors = 0;
    int checks = 0;
    bit slow_tick = 1'b0;
    int phase = 0;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One rising edge; outputs are sampled 1 ns later.
    task automatic step();
        if (slow_tick) begin
            bus.clk_48KHz_en = (phase == 0);
            phase = (phase == 2) ? 0 : phase + 1;
        end else begin
            bus.clk_48KHz_en = 1'b1;
        end
        bus1.clk_48KHz_en = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_in();
        bus.wr_en = 1'b0;  bus.wr_data = 4'd0;  bus.trig_big = 1'b0;  bus.trig_small = 1'b0;
        bus1.wr_en = 1'b0; bus1.wr_data = 4'd0; bus1.trig_big = 1'b0; bus1.trig_small = 1'b0;
    endtask

    initial begin
        bit seen;
        int cycles;
        int ticks;

        clear_in();
        bus.clk_48KHz_en  = 1'b1;
        bus1.clk_48KHz_en = 1'b1;
        rst = 1'b1;
        steps(2);
        check_val("rst_crsh", bus.crsh, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);

        // Reset beats a simultaneous trigger.
        bus.trig_big = 1'b1;
        step();
        clear_in();
        check_val("rst_over_trig", bus.crsh, 0);
        rst = 1'b0;

        // Full big-trigger envelope: 4 + 15*2 = 34 edges.
        bus.trig_big = 1'b1;
        step();
        clear_in();
        check_val("big_e0_crsh", bus.crsh, 15);
        check_val("big_e0_busy", bus.busy, 1);
        steps(5);
        check_val("big_e5_crsh", bus.crsh, 15);
        step();
        check_val("big_e6_crsh", bus.crsh, 14);
        steps(27);
        check_val("big_e33_crsh", bus.crsh, 1);
        check_val("big_e33_done", bus.done, 0);
        step();
        check_val("big_e34_crsh", bus.crsh, 0);
        check_val("big_e34_done", bus.done, 1);
        check_val("big_e34_busy", bus.busy, 0);
        step();
        check_val("big_e35_done", bus.done, 0);

        // Small trigger ignored while level 13 > 8.
        bus.trig_big = 1'b1;
        step();
        clear_in();
        steps(8);
        check_val("ign_e8_crsh", bus.crsh, 13);
        bus.trig_small = 1'b1;
        step();
        clear_in();
        check_val("ign_e9_crsh", bus.crsh, 13);
        step();
        check_val("ign_e10_crsh", bus.crsh, 12);

        // Write of 0 mid-decay: silent, idle, no done pulse.
        bus.wr_en = 1'b1; bus.wr_data = 4'd0;
        step();
        clear_in();
        check_val("wr0_crsh", bus.crsh, 0);
        check_val("wr0_busy", bus.busy, 0);
        seen = bus.done;
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.done) seen = 1'b1;
        end
        check_val("wr0_no_done", seen, 0);

        // Big beats small; write beats big and parks in MANUAL.
        bus.trig_big = 1'b1; bus.trig_small = 1'b1;
        step();
        clear_in();
        check_val("big_vs_small", bus.crsh, 15);
        bus.wr_en = 1'b1; bus.wr_data = 4'd5; bus.trig_big = 1'b1;
        step();
        clear_in();
        check_val("wr_vs_big", bus.crsh, 5);
        check_val("manual_busy", bus.busy, 1);
        seen = 1'b0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.crsh != 4'd5) seen = 1'b1;
        end
        check_val("manual_hold", seen, 0);
        check_val("manual_crsh", bus.crsh, 5);

        // Small accepted from MANUAL at level 5, then decays normally.
        bus.trig_small = 1'b1;
        step();
        clear_in();
        check_val("small_from_man", bus.crsh, 8);
        steps(6);
        check_val("small_e6_crsh", bus.crsh, 7);

        // Reset mid-decay at level 9, then a small trigger on the next cycle.
        bus.trig_big = 1'b1;
        step();
        clear_in();
        steps(17);
        check_val("pre_rst_crsh", bus.crsh, 9);
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_val("mid_rst_crsh", bus.crsh, 0);
        check_val("mid_rst_busy", bus.busy, 0);
        check_val("mid_rst_done", bus.done, 0);
        bus.trig_small = 1'b1;
        step();
        clear_in();
        check_val("post_rst_small", bus.crsh, 8);
        check_val("post_rst_busy", bus.busy, 1);

        // Sparse ticks: small level 8 needs 4 + 8*2 = 20 ticks, one every 3 cycles.
        bus.wr_en = 1'b1; bus.wr_data = 4'd0;
        step();
        clear_in();
        slow_tick = 1'b1;
        phase = 0;
        bus.trig_small = 1'b1;
        step();
        clear_in();
        cycles = 0;
        ticks = 0;
        while (cycles < 200) begin
            step();
            cycles++;
            if (bus.clk_48KHz_en) ticks++;
            if (bus.crsh == 4'd0) break;
        end
        slow_tick = 1'b0;
        check_val("slow_cycles", cycles, 60);
        check_val("slow_ticks", ticks, 20);
        check_val("slow_done", bus.done, 1);

        // Single-tick hold and decay: 1 + 15*1 = 16 ticks to silence.
        bus1.trig_big = 1'b1;
        step();
        clear_in();
        check_val("t1_e0_crsh", bus1.crsh, 15);
        step();
        check_val("t1_e1_crsh", bus1.crsh, 15);
        step();
        check_val("t1_e2_crsh", bus1.crsh, 14);
        steps(13);
        check_val("t1_e15_crsh", bus1.crsh, 1);
        step();
        check_val("t1_e16_crsh", bus1.crsh, 0);
        check_val("t1_e16_done", bus1.done, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
